crc_stream_engine: RTL
======================

# crc_stream_engine

Parametrised, streaming CRC block that replaces the fixed 16-bit generator/checker pair. One instance either generates a CRC and appends it to a framed data stream, or checks a received frame whose final word carries the CRC, selected per frame. The block uses valid/ready handshakes on both sides and keeps a saturating error counter. It sits between the framed data source and the link or status logic; the LED/status path consumes `o_chk_ok`.

## Interface
- `DATA_W`, 16: data word width; legal values are 8, 16 and 32.
- `CRC_W`, 16: CRC width; must satisfy 4 ≤ CRC_W ≤ DATA_W.
- `POLY`, 16'h1021: generator polynomial, normal (non-reflected) form, implicit top bit.
- `INIT`, 16'hFFFF: CRC register value at frame start.
- `XOR_OUT`, 16'h0000: value XORed onto the final CRC.
- `CNT_W`, 16: error counter width.
- `i_clk`  in  1  sole clock; all logic is rising-edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_mode`  in  1  0 = generate, 1 = check; sampled with the first accepted word of each frame.
- `i_din_valid`  in  1  input word valid.
- `o_din_ready`  out  1  block can accept an input word.
- `i_din`  in  DATA_W  input word.
- `i_din_last`  in  1  marks the final word of the frame.
- `o_dout_valid`  out  1  output word valid (generate mode only).
- `i_dout_ready`  in  1  downstream accepts the output word.
- `o_dout`  out  DATA_W  output word.
- `o_dout_last`  out  1  asserted only on the appended CRC word.
- `o_chk_valid`  out  1  one-cycle pulse carrying the check result.
- `o_chk_ok`  out  1  check passed; held until the next `o_chk_valid`.
- `o_err_cnt`  out  CNT_W  number of failed checks, saturating.
- `o_busy`  out  1  a frame is in progress, or the appended CRC is still pending.

## Operation
- **CRC arithmetic**
  - MSB-first and non-reflected; one full DATA_W word is absorbed per accepted beat.
  - Combinational, unrolled over DATA_W bits.
  - Final value is `crc_reg ^ XOR_OUT`.
  - A CRC word is placed in `o_dout[CRC_W-1:0]` with the upper bits zero.
- **Handshakes**
  - An input beat transfers when `i_din_valid && o_din_ready`.
  - An output beat transfers when `o_dout_valid && i_dout_ready`.
  - `o_dout` and `o_dout_last` are held stable while `o_dout_valid && !i_dout_ready`.
- **FSM states**
  - IDLE: `crc_reg` = INIT.
  - FRAME: accepting words.
  - APPEND: generate mode only, CRC word pending.
- **IDLE → FRAME**: on the first accepted beat without last; latch the mode.
- **Single-word frame**: a first beat with last goes to APPEND (generate) or stays in IDLE (check).
- **Generate mode**
  - Each accepted word is registered into a one-entry output register and forwarded with `o_dout_last` = 0.
  - `o_din_ready` = `(state != APPEND) && (!o_dout_valid || i_dout_ready)`.
  - On the last beat: enter APPEND and hold the final CRC.
  - The CRC word loads into the output register as soon as it is free, with `o_dout_last` = 1.
  - When that beat transfers, return to IDLE.
- **Check mode**
  - Nothing is forwarded; `o_dout_valid` stays 0 and `o_din_ready` = 1.
  - Non-last words update `crc_reg`.
  - The last word is not absorbed. It is compared: ok = `(crc_reg ^ XOR_OUT) == i_din[CRC_W-1:0]`.
  - Then pulse `o_chk_valid`, update `o_chk_ok`, and return to IDLE with `crc_reg` = INIT.
  - A single-word check frame compares against `INIT ^ XOR_OUT`.
- **Error counter**: increments on each failed check and saturates at all-ones.
- **Mode changes**: changes to `i_mode` mid-frame are ignored.
- **Reset**: asserting `i_rst_n` mid-frame aborts the frame immediately; no partial CRC or result is emitted.

## Timing
- **Reset values**
  - `o_din_ready` = 1.
  - `o_dout_valid`, `o_dout_last`, `o_chk_valid`, `o_chk_ok` and `o_busy` = 0.
  - `o_dout` and `o_err_cnt` = 0.
  - State = IDLE; `crc_reg` = INIT.
- **Generate latency**
  - A word accepted at edge N is valid on `o_dout` after edge N.
  - With `i_dout_ready` held at 1, the CRC word is valid one cycle after the last data word.
  - `o_din_ready` is low during that cycle; the next frame starts one cycle later.
- **Check latency**
  - Last word accepted at edge N: `o_chk_valid` is high for exactly the cycle after edge N.
  - `o_err_cnt` updates on the same edge.
  - Back-to-back check frames run with no gap.
- **`o_busy`**: high from the first accepted beat until the return to IDLE.

## Test plan
1. Reset values: assert `i_rst_n` = 0 asynchronously, mid-cycle → all outputs reach their reset values without waiting for a clock edge; `o_din_ready` = 1.
2. Generate, with INIT = 0 and DATA_W = CRC_W = 16:
   - Frame 0x0000, 0x0001 (last), `i_dout_ready` = 1 → `o_dout` = 0x0000, 0x0001, then 0x1021 with `o_dout_last` = 1.
   - `o_din_ready` = 0 during the CRC cycle.
3. Check, with INIT = 0:
   - Frame 0x0001, 0x1021 (last) → `o_chk_valid` pulse with `o_chk_ok` = 1; `o_err_cnt` = 0.
   - Frame 0x0001, 0x1020 (last) → `o_chk_ok` = 0; `o_err_cnt` = 1.
4. Backpressure: generate a 4-word frame with `i_dout_ready` toggling at random → output words stay stable while stalled, there is no loss or duplication, and the CRC matches the software model for default parameters.
5. Counter saturation: with CNT_W = 2, send 5 bad check frames → `o_err_cnt` = 3.
6. Reset mid-frame and mode change:
   - Reset after 2 words of a generate frame → no CRC word is emitted; the next frame's CRC equals the software model from INIT.
   - Flipping `i_mode` mid-frame → no effect on that frame.

Source files
------------

// File: rtl/crc_stream_engine.sv
// Streaming MSB-first CRC engine: per frame either appends the CRC to the data
// stream (generate) or compares a trailing CRC word (check), with a saturating error count.
module crc_stream_engine #(
    parameter int unsigned           DATA_W  = 16,
    parameter int unsigned           CRC_W   = 16,
    parameter logic [CRC_W-1:0]      POLY    = 16'h1021,
    parameter logic [CRC_W-1:0]      INIT    = 16'hFFFF,
    parameter logic [CRC_W-1:0]      XOR_OUT = 16'h0000,
    parameter int unsigned           CNT_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_mode,
    input  logic              i_din_valid,
    output logic              o_din_ready,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_din_last,
    output logic              o_dout_valid,
    input  logic              i_dout_ready,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_dout_last,
    output logic              o_chk_valid,
    output logic              o_chk_ok,
    output logic [CNT_W-1:0]  o_err_cnt,
    output logic              o_busy
);

    typedef enum logic [1:0] {IDLE, FRAME, APPEND} state_t;

    state_t              state_q, state_d;
    logic [CRC_W-1:0]    crc_q, crc_d;
    logic                mode_q, mode_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                dout_last_q, dout_last_d;
    logic                chk_valid_q, chk_valid_d;
    logic                chk_ok_q, chk_ok_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

    logic                in_fire, out_fire, cur_mode, chk_match;
    logic [CRC_W-1:0]    crc_upd;

    function automatic logic [CRC_W-1:0] crc_word(input logic [CRC_W-1:0] crc,
                                                   input logic [DATA_W-1:0] data);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = crc;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            fb = c[CRC_W-1] ^ data[DATA_W-1-i];
            c  = {c[CRC_W-2:0], 1'b0};
            if (fb) c = c ^ POLY;
        end
        return c;
    endfunction

    assign crc_upd   = crc_word(crc_q, i_din);
    assign chk_match = ((crc_q ^ XOR_OUT) == i_din[CRC_W-1:0]);
    // Mode is only taken from the port on a frame's first beat.
    assign cur_mode  = (state_q == IDLE) ? i_mode : mode_q;
    assign in_fire   = i_din_valid && o_din_ready;
    assign out_fire  = dout_valid_q && i_dout_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            crc_q        <= INIT;
            mode_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            chk_valid_q  <= 1'b0;
            chk_ok_q     <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            mode_q       <= mode_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            chk_valid_q  <= chk_valid_d;
            chk_ok_q     <= chk_ok_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, FRAME: begin
                if (in_fire) begin
                    if (i_din_last) state_d = cur_mode ? IDLE : APPEND;
                    else            state_d = FRAME;
                end
            end
            APPEND:  if (dout_last_q && out_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        crc_d        = crc_q;
        mode_d       = mode_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        dout_last_d  = dout_last_q;
        chk_valid_d  = 1'b0;
        chk_ok_d     = chk_ok_q;
        err_cnt_d    = err_cnt_q;
        if (out_fire) begin
            dout_valid_d = 1'b0;
            dout_last_d  = 1'b0;
        end
        if (state_q == APPEND) begin
            if (dout_last_q) begin
                if (out_fire) crc_d = INIT;
            end else if (!dout_valid_q || out_fire) begin
                dout_d              = '0;
                dout_d[CRC_W-1:0]   = crc_q ^ XOR_OUT;
                dout_valid_d        = 1'b1;
                dout_last_d         = 1'b1;
            end
        end else if (in_fire) begin
            if (state_q == IDLE) mode_d = i_mode;
            if (!cur_mode) begin
                dout_d       = i_din;
                dout_valid_d = 1'b1;
                dout_last_d  = 1'b0;
                crc_d        = crc_upd;
            end else if (i_din_last) begin
                // The trailing word is compared, never absorbed.
                chk_valid_d = 1'b1;
                chk_ok_d    = chk_match;
                if (!chk_match && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
                crc_d       = INIT;
            end else begin
                crc_d = crc_upd;
            end
        end
    end

    always_comb begin
        o_din_ready  = (state_q != APPEND) && (!dout_valid_q || i_dout_ready);
        o_busy       = (state_q != IDLE);
        o_dout_valid = dout_valid_q;
        o_dout       = dout_q;
        o_dout_last  = dout_last_q;
        o_chk_valid  = chk_valid_q;
        o_chk_ok     = chk_ok_q;
        o_err_cnt    = err_cnt_q;
    end

endmodule
